// File: rtl/noc_pkg.sv
// Shared router definitions: port indices, port count and the idle crossbar select code.
package noc_pkg;
   localparam int NUM_PORTS = 5;

   typedef logic [2:0] port_idx_t;

   localparam port_idx_t PORT_N   = 3'd0;
   localparam port_idx_t PORT_S   = 3'd1;
   localparam port_idx_t PORT_E   = 3'd2;
   localparam port_idx_t PORT_W   = 3'd3;
   localparam port_idx_t PORT_L   = 3'd4;
   localparam port_idx_t SEL_IDLE = 3'd7;

   // Cyclic successor on the 5-port ring.
   function automatic port_idx_t next_port(input port_idx_t p);
      return (p == PORT_L) ? PORT_N : p + 3'd1;
   endfunction
endpackage

// File: rtl/switch_allocator_if.sv
// Allocator request/grant bundle; master = router datapath, slave = switch_allocator.
interface switch_allocator_if;
   logic [4:0]  req_valid_i;
   logic [14:0] req_dest_i;
   logic [4:0]  out_full_i;
   logic [4:0]  pop_o;
   logic [4:0]  out_enable_o;
   logic [14:0] out_select_o;
   logic [4:0]  credit_o;
   logic [4:0]  urgent_o;

   modport master (
      output req_valid_i, req_dest_i, out_full_i,
      input  pop_o, out_enable_o, out_select_o, credit_o, urgent_o
   );

   modport slave (
      input  req_valid_i, req_dest_i, out_full_i,
      output pop_o, out_enable_o, out_select_o, credit_o, urgent_o
   );
endinterface

// File: rtl/switch_allocator_rr_arbiter5.sv
// Purpose: 5-way round-robin pick starting at ptr, urgent requesters taking precedence.
// Latency: combinational.
// Backpressure: none here; callers mask full outputs out of the eligible vector.
module rr_arbiter5
   import noc_pkg::*;
(
   input  logic [4:0] eligible,
   input  logic [4:0] urgent,
   input  port_idx_t  ptr,
   output logic       grant_valid,
   output port_idx_t  grant_idx
);

   logic [4:0] cand;
   port_idx_t  idx;
   logic       found;

   always_comb begin
      // Non-urgent requesters only compete when no urgent one is eligible.
      cand      = (|(eligible & urgent)) ? (eligible & urgent) : eligible;
      grant_idx = SEL_IDLE;
      found     = 1'b0;
      idx       = ptr;
      for (int k = 0; k < NUM_PORTS; k++) begin
         if (!found && cand[idx]) begin
            grant_idx = idx;
            found     = 1'b1;
         end
         idx = next_port(idx);
      end
      grant_valid = found;
   end

endmodule

// File: rtl/switch_allocator.sv
// Purpose: per-output round-robin switch allocation (aging with SWALLOC_AGE_EN).
// Latency: grants combinational from requests; pointers/counters/credits update next edge.
// Backpressure: out_full_i removes an output from arbitration; its pointer holds.
module switch_allocator
   import noc_pkg::*;
#(
   parameter logic [4:0] PORT_MASK   = 5'b11111,
   parameter bit         ALLOW_UTURN = 1'b0,
   parameter int         MAX_WAIT    = 15,
   parameter int         WAIT_W      = 4
) (
   input  logic               clk,
   input  logic               rst,
   switch_allocator_if.slave  bus
);

   if (MAX_WAIT >= (1 << WAIT_W)) begin : g_bad_cfg
      $error("MAX_WAIT must fit in WAIT_W bits");
   end

   logic [4:0] elig [NUM_PORTS];
   port_idx_t  ptr [NUM_PORTS];
   logic [4:0] gnt_vld;
   port_idx_t  gnt_idx [NUM_PORTS];
   logic [4:0] urgent;
   logic [4:0] en;
   logic [4:0] pop;
   logic [4:0] credit;

   always_comb begin
      port_idx_t dest;
      dest = '0;
      for (int o = 0; o < NUM_PORTS; o++) begin
         elig[o] = '0;
         for (int i = 0; i < NUM_PORTS; i++) begin
            dest = bus.req_dest_i[3*i +: 3];
            elig[o][i] = bus.req_valid_i[i] && PORT_MASK[i] && PORT_MASK[o]
                         && !bus.out_full_i[o] && (dest == port_idx_t'(o))
                         && (ALLOW_UTURN || (dest != port_idx_t'(i)));
         end
      end
   end

   for (genvar o = 0; o < NUM_PORTS; o++) begin : g_arb
      rr_arbiter5 u_arb (
         .eligible    (elig[o]),
         .urgent      (urgent),
         .ptr         (ptr[o]),
         .grant_valid (gnt_vld[o]),
         .grant_idx   (gnt_idx[o])
      );
   end

   // Reset squashes grants so nothing pops and no credit follows.
   always_comb begin
      en               = gnt_vld & {5{~rst}};
      pop              = '0;
      bus.out_select_o = {5{SEL_IDLE}};
      for (int o = 0; o < NUM_PORTS; o++) begin
         if (en[o]) begin
            bus.out_select_o[3*o +: 3] = gnt_idx[o];
            pop[gnt_idx[o]]            = 1'b1;
         end
      end
   end

   assign bus.pop_o        = pop;
   assign bus.out_enable_o = en;
   assign bus.credit_o     = credit;

   always_ff @(posedge clk) begin
      if (rst) begin
         credit <= '0;
         for (int o = 0; o < NUM_PORTS; o++) ptr[o] <= PORT_N;
      end else begin
         credit <= pop;
         for (int o = 0; o < NUM_PORTS; o++) begin
            if (en[o]) ptr[o] <= next_port(gnt_idx[o]);
         end
      end
   end

`ifdef SWALLOC_AGE_EN
   logic [WAIT_W-1:0] wait_cnt [NUM_PORTS];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_PORTS; i++) wait_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            if (!bus.req_valid_i[i] || !PORT_MASK[i] || pop[i])
               wait_cnt[i] <= '0;
            else if (wait_cnt[i] != WAIT_W'(MAX_WAIT))
               wait_cnt[i] <= wait_cnt[i] + 1'b1;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_PORTS; i++) urgent[i] = (wait_cnt[i] == WAIT_W'(MAX_WAIT));
   end

   assign bus.urgent_o = urgent & {5{~rst}};
`else
   assign urgent       = '0;
   assign bus.urgent_o = '0;
`endif

endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator: vector table plus reset, back-pressure, aging and mask sequences.
module tb_switch_allocator;
   import noc_pkg::*;

`ifdef SWALLOC_AGE_EN
   localparam bit AGE = 1'b1;
`else
   localparam bit AGE = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   switch_allocator_if if0 ();
   switch_allocator_if if1 ();

   switch_allocator #(.PORT_MASK(5'b11111), .ALLOW_UTURN(1'b0), .MAX_WAIT(3), .WAIT_W(4))
      u_dut (.clk(clk), .rst(rst), .bus(if0));

   switch_allocator #(.PORT_MASK(5'b10111), .ALLOW_UTURN(1'b0), .MAX_WAIT(3), .WAIT_W(4))
      u_wedge (.clk(clk), .rst(rst), .bus(if1));

   typedef struct {
      logic [4:0]  valid;
      logic [14:0] dest;
      logic [4:0]  full;
      logic [4:0]  pop;
      logic [4:0]  en;
      logic [14:0] sel;
      logic [4:0]  urg;
   } vec_t;

   vec_t       vt [15];
   logic [4:0] prev_pop;

   function automatic logic [14:0] pk5(input int a0, input int a1, input int a2,
                                       input int a3, input int a4);
      return {3'(a4), 3'(a3), 3'(a2), 3'(a1), 3'(a0)};
   endfunction

   task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %h required %h", name, act, exp);
      end
   endtask

   task automatic step(input logic [4:0] v, input logic [14:0] d, input logic [4:0] f);
      @(posedge clk);
      #1;
      if0.req_valid_i = v;
      if0.req_dest_i  = d;
      if0.out_full_i  = f;
   endtask

   task automatic check(input string tag, input logic [4:0] ep, input logic [4:0] ee,
                        input logic [14:0] es, input logic [4:0] ec, input logic [4:0] eu);
      @(negedge clk);
      cmp({tag, ".pop"},    16'(if0.pop_o),        16'(ep));
      cmp({tag, ".enable"}, 16'(if0.out_enable_o), 16'(ee));
      cmp({tag, ".select"}, 16'(if0.out_select_o), 16'(es));
      cmp({tag, ".credit"}, 16'(if0.credit_o),     16'(ec));
      cmp({tag, ".urgent"}, 16'(if0.urgent_o),     16'(eu));
   endtask

   initial begin
      logic [14:0] idle_sel;
      idle_sel = pk5(7, 7, 7, 7, 7);

      // N,E,L contend for S starting from ptr 0, then mixed traffic, parallel grants and corners.
      vt[0]  = '{5'b10101, pk5(1,0,1,0,1), 5'b00000, 5'b00001, 5'b00010, pk5(7,0,7,7,7), 5'b0};
      vt[1]  = '{5'b10101, pk5(1,0,1,0,1), 5'b00000, 5'b00100, 5'b00010, pk5(7,2,7,7,7), 5'b0};
      vt[2]  = '{5'b10101, pk5(1,0,1,0,1), 5'b00000, 5'b10000, 5'b00010, pk5(7,4,7,7,7), 5'b0};
      vt[3]  = '{5'b10101, pk5(1,0,1,0,1), 5'b00000, 5'b00001, 5'b00010, pk5(7,0,7,7,7), 5'b0};
      vt[4]  = '{5'b10101, pk5(1,0,1,0,1), 5'b00000, 5'b00100, 5'b00010, pk5(7,2,7,7,7), 5'b0};
      vt[5]  = '{5'b10101, pk5(1,0,1,0,1), 5'b00000, 5'b10000, 5'b00010, pk5(7,4,7,7,7), 5'b0};
      vt[6]  = '{5'b11111, pk5(1,0,1,0,2), 5'b00000, 5'b10011, 5'b00111, pk5(1,0,4,7,7), 5'b0};
      vt[7]  = '{5'b11111, pk5(1,0,1,0,2), 5'b00000, 5'b11100, 5'b00111, pk5(3,2,4,7,7), 5'b0};
      vt[8]  = '{5'b11111, pk5(1,0,1,0,2), 5'b00000, 5'b10011, 5'b00111, pk5(1,0,4,7,7), 5'b0};
      vt[9]  = '{5'b10111, pk5(1,0,4,0,2), 5'b00000, 5'b10111, 5'b10111, pk5(1,0,4,7,2), 5'b0};
      vt[10] = '{5'b00011, pk5(0,1,0,0,0), 5'b00000, 5'b00000, 5'b00000, idle_sel,       5'b0};
      vt[11] = '{5'b01100, pk5(0,0,7,5,0), 5'b00000, 5'b00000, 5'b00000, idle_sel,       5'b0};
      vt[12] = '{5'b11111, pk5(1,0,1,0,2), 5'b11111, 5'b00000, 5'b00000, idle_sel,       5'b0};
      vt[13] = '{5'b11111, pk5(1,0,1,0,2), 5'b00010, 5'b11000, 5'b00101, pk5(3,7,4,7,7), 5'b0};
      vt[14] = '{5'b00000, pk5(0,0,0,0,0), 5'b00000, 5'b00000, 5'b00000, idle_sel,
                 AGE ? 5'b00100 : 5'b00000};

      rst = 1'b1;
      if0.req_valid_i = 5'b11111;
      if0.req_dest_i  = pk5(1, 2, 3, 4, 0);
      if0.out_full_i  = 5'b00000;
      if1.req_valid_i = 5'b00000;
      if1.req_dest_i  = '0;
      if1.out_full_i  = 5'b00000;

      check("reset0", 5'b0, 5'b0, 15'h7FFF, 5'b0, 5'b0);
      check("reset1", 5'b0, 5'b0, 15'h7FFF, 5'b0, 5'b0);

      step(5'b0, 15'h0, 5'b0);
      rst = 1'b0;
      check("idle", 5'b0, 5'b0, idle_sel, 5'b0, 5'b0);
      prev_pop = 5'b0;

      for (int k = 0; k < 15; k++) begin
         step(vt[k].valid, vt[k].dest, vt[k].full);
         check($sformatf("vec%0d", k), vt[k].pop, vt[k].en, vt[k].sel, prev_pop, vt[k].urg);
         prev_pop = vt[k].pop;
      end

      // L requests N while N is full for 4 cycles; ptr_N must hold then wrap to 0.
      for (int c = 0; c < 4; c++) begin
         step(5'b10000, pk5(0,0,0,0,0), 5'b00001);
         check($sformatf("full%0d", c), 5'b0, 5'b0, idle_sel, 5'b0,
               (AGE && c == 3) ? 5'b10000 : 5'b00000);
      end
      step(5'b10000, pk5(0,0,0,0,0), 5'b00000);
      check("full_clear", 5'b10000, 5'b00001, pk5(4,7,7,7,7), 5'b0, AGE ? 5'b10000 : 5'b0);
      step(5'b10010, pk5(0,0,0,0,0), 5'b00000);
      check("ptr_wrap", 5'b00010, 5'b00001, pk5(1,7,7,7,7), 5'b10000, 5'b0);

      // Reset lands on a cycle with live grants.
      step(5'b01010, pk5(0,0,0,0,0), 5'b00000);
      rst = 1'b1;
      check("mid_rst", 5'b0, 5'b0, idle_sel, 5'b00010, 5'b0);
      step(5'b01010, pk5(0,0,0,0,0), 5'b00000);
      rst = 1'b0;
      check("post_rst", 5'b00010, 5'b00001, pk5(1,7,7,7,7), 5'b0, 5'b0);

      // E waits on full L for 3 cycles, then competes with N for L at ptr_L = 0.
      step(5'b00100, pk5(0,0,4,0,0), 5'b10000);
      check("age0", 5'b0, 5'b0, idle_sel, 5'b00010, 5'b0);
      step(5'b00100, pk5(0,0,4,0,0), 5'b10000);
      check("age1", 5'b0, 5'b0, idle_sel, 5'b0, 5'b0);
      step(5'b00100, pk5(0,0,4,0,0), 5'b10000);
      check("age2", 5'b0, 5'b0, idle_sel, 5'b0, 5'b0);
      step(5'b00101, pk5(4,0,4,0,0), 5'b00000);
      check("age_win", AGE ? 5'b00100 : 5'b00001, 5'b10000,
            AGE ? pk5(7,7,7,7,2) : pk5(7,7,7,7,0), 5'b0, AGE ? 5'b00100 : 5'b0);
      prev_pop = AGE ? 5'b00100 : 5'b00001;

      // Wedge tile: W absent, S U-turn ignored, L->E granted.
      step(5'b00000, pk5(0,0,0,0,0), 5'b00000);
      if1.req_valid_i = 5'b11011;
      if1.req_dest_i  = pk5(3, 1, 0, 0, 2);
      check("age_credit", 5'b0, 5'b0, idle_sel, prev_pop, 5'b0);
      cmp("mask.pop",    16'(if1.pop_o),        16'(5'b10000));
      cmp("mask.enable", 16'(if1.out_enable_o), 16'(5'b00100));
      cmp("mask.select", 16'(if1.out_select_o), 16'(pk5(7,7,4,7,7)));
      @(posedge clk);
      #1;
      if1.req_valid_i = 5'b00000;
      @(negedge clk);
      cmp("mask.credit", 16'(if1.credit_o), 16'(5'b10000));
      cmp("mask.pop_idle", 16'(if1.pop_o), 16'(5'b00000));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
